// File: rtl/rv_decode_stage.sv
// RISC-V decoder: static decode of the fetch word plus a registered stage
// applying privilege/CSR/FP legality checks. Optional FP via DECODER_FP_EN.
module rv_decode_stage #(
  parameter int XLEN = 64,
  parameter int ID_W = 20
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     data_i,
  input  logic            input_ready_i,
  input  logic [1:0]      fs_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic [2:0]      frm_i,
  input  logic            tvm_i,
  input  logic            tw_i,
  input  logic            tsr_i,
  input  logic            debug_mode_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     tinst_o,
  output logic            si_valid_o,
  output logic [2:0]      fu_o,
  output logic [3:0]      op_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [XLEN-1:0] imm_o,
  output logic            exc_valid_o,
  output logic [3:0]      exc_cause_o,
  output logic [XLEN-1:0] exc_tval_o
);
  localparam logic [2:0] FU_ALU = 3'd0;
  localparam logic [2:0] FU_BRU = 3'd1;
  localparam logic [2:0] FU_LSU = 3'd2;
  localparam logic [2:0] FU_CSR = 3'd3;
  localparam logic [2:0] FU_FPU = 3'd4;
  localparam logic [2:0] FU_NONE = 3'd7;

  localparam logic [31:0] W_ECALL = 32'h0000_0073;
  localparam logic [31:0] W_EBRK = 32'h0010_0073;
  localparam logic [31:0] W_MRET = 32'h3020_0073;
  localparam logic [31:0] W_SRET = 32'h1020_0073;
  localparam logic [31:0] W_WFI = 32'h1050_0073;
  localparam logic [31:0] W_DRET = 32'h7b20_0073;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [11:0]     w_csr;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_uimm;

  assign w_opc = data_i[6:0];
  assign w_f3 = data_i[14:12];
  assign w_f7 = data_i[31:25];
  assign w_csr = data_i[31:20];
  assign w_imm_i = {{(XLEN-12){data_i[31]}}, data_i[31:20]};
  assign w_imm_s = {{(XLEN-12){data_i[31]}},
                    data_i[31:25], data_i[11:7]};
  assign w_imm_b = {{(XLEN-13){data_i[31]}}, data_i[31],
                    data_i[7], data_i[30:25], data_i[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){data_i[31]}}, data_i[31:12], 12'h0};
  assign w_imm_j = {{(XLEN-21){data_i[31]}}, data_i[31],
                    data_i[19:12], data_i[20], data_i[30:21], 1'b0};
  assign w_uimm = {{(XLEN-5){1'b0}}, data_i[19:15]};

  logic            w_sv;
  logic [2:0]      w_fu;
  logic [XLEN-1:0] w_imm;
  logic            w_fp;
  logic            w_rm_use;

  // static decode: well-formedness, unit and immediate
  always_comb begin
    w_sv = 1'b0;
    w_fu = FU_NONE;
    w_imm = '0;
    w_fp = 1'b0;
    w_rm_use = 1'b0;
    case (w_opc)
      7'b0110111, 7'b0010111: begin
        w_sv = 1'b1;
        w_fu = FU_ALU;
        w_imm = w_imm_u;
      end
      7'b0010011: begin
        w_fu = FU_ALU;
        w_imm = w_imm_i;
        case (w_f3)
          3'd1: w_sv = data_i[31:26] == 6'b000000;
          3'd5: w_sv = data_i[31:26] == 6'b000000 ||
                       data_i[31:26] == 6'b010000;
          default: w_sv = 1'b1;
        endcase
      end
      7'b0110011: begin
        w_fu = FU_ALU;
        w_sv = w_f7 == 7'h00 ||
               (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
      end
      7'b0011011: begin
        w_fu = FU_ALU;
        w_imm = w_imm_i;
        case (w_f3)
          3'd0: w_sv = 1'b1;
          3'd1: w_sv = w_f7 == 7'h00;
          3'd5: w_sv = w_f7 == 7'h00 || w_f7 == 7'h20;
          default: w_sv = 1'b0;
        endcase
      end
      7'b0111011: begin
        w_fu = FU_ALU;
        case (w_f3)
          3'd0, 3'd5: w_sv = w_f7 == 7'h00 || w_f7 == 7'h20;
          3'd1: w_sv = w_f7 == 7'h00;
          default: w_sv = 1'b0;
        endcase
      end
      7'b1101111: begin
        w_sv = 1'b1;
        w_fu = FU_BRU;
        w_imm = w_imm_j;
      end
      7'b1100111: begin
        w_sv = w_f3 == 3'd0;
        w_fu = FU_BRU;
        w_imm = w_imm_i;
      end
      7'b1100011: begin
        w_sv = w_f3 != 3'd2 && w_f3 != 3'd3;
        w_fu = FU_BRU;
        w_imm = w_imm_b;
      end
      7'b0000011: begin
        w_sv = w_f3 != 3'd7;
        w_fu = FU_LSU;
        w_imm = w_imm_i;
      end
      7'b0100011: begin
        w_sv = !w_f3[2];
        w_fu = FU_LSU;
        w_imm = w_imm_s;
      end
      7'b0001111: begin
        w_sv = w_f3 == 3'd0 || w_f3 == 3'd1;
        w_fu = FU_LSU;
        w_imm = w_imm_i;
      end
      7'b1110011: begin
        w_fu = FU_CSR;
        if (w_f3 == 3'd0) begin
          w_sv = data_i == W_ECALL || data_i == W_EBRK ||
                 data_i == W_MRET || data_i == W_SRET ||
                 data_i == W_WFI || data_i == W_DRET ||
                 (w_f7 == 7'b0001001 && data_i[14:7] == 8'h0);
        end else begin
          w_sv = w_f3 != 3'd4;
          w_imm = w_f3[2] ? w_uimm : w_imm_i;
        end
      end
`ifdef DECODER_FP_EN
      7'b0000111: begin
        w_sv = w_f3 == 3'd2 || w_f3 == 3'd3;
        w_fu = FU_FPU;
        w_fp = 1'b1;
        w_imm = w_imm_i;
      end
      7'b0100111: begin
        w_sv = w_f3 == 3'd2 || w_f3 == 3'd3;
        w_fu = FU_FPU;
        w_fp = 1'b1;
        w_imm = w_imm_s;
      end
      7'b1010011: begin
        w_sv = !w_f7[1];
        w_fu = FU_FPU;
        w_fp = 1'b1;
        case (w_f7[6:2])
          5'h00, 5'h01, 5'h02, 5'h03, 5'h0b,
          5'h08, 5'h18, 5'h1a: w_rm_use = 1'b1;
          default: w_rm_use = 1'b0;
        endcase
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        w_sv = !data_i[26];
        w_fu = FU_FPU;
        w_fp = 1'b1;
        w_rm_use = 1'b1;
      end
`endif
      default: w_sv = 1'b0;
    endcase
    if (data_i[1:0] != 2'b11) w_sv = 1'b0;
  end

`ifndef DECODER_FP_EN
  logic w_unused_fp;
  assign w_unused_fp = ^{fs_i, frm_i, w_fp, w_rm_use};
`endif

  logic w_is_csr;
  logic w_csr_wr;
  logic w_ill;
  logic w_fp_ill;
  logic w_ecall;
  logic w_ebrk;
  logic [3:0] w_op;

  assign w_is_csr = w_opc == 7'b1110011 && w_f3 != 3'd0;
  assign w_csr_wr = w_f3[1:0] == 2'b01 || data_i[19:15] != 5'd0;

`ifdef DECODER_FP_EN
  assign w_fp_ill = w_fp && (fs_i == 2'd0 ||
    (w_rm_use && (w_f3 == 3'd5 || w_f3 == 3'd6)) ||
    (w_rm_use && w_f3 == 3'd7 && frm_i >= 3'd5));
`else
  assign w_fp_ill = 1'b0;
`endif

  assign w_ill = !w_sv ||
    (w_is_csr && w_csr[9:8] > priv_lvl_i) ||
    (w_is_csr && w_csr[11:10] == 2'b11 && w_csr_wr) ||
    (w_is_csr && w_csr == 12'h180 && priv_lvl_i == 2'd1 && tvm_i) ||
    (data_i == W_MRET && priv_lvl_i != 2'd3) ||
    (data_i == W_SRET && (priv_lvl_i == 2'd0 ||
      (priv_lvl_i == 2'd1 && tsr_i))) ||
    (data_i == W_WFI && tw_i && priv_lvl_i != 2'd3) ||
    (w_opc == 7'b1110011 && w_f3 == 3'd0 && w_f7 == 7'b0001001 &&
      (priv_lvl_i == 2'd0 || (priv_lvl_i == 2'd1 && tvm_i))) ||
    (data_i == W_DRET && !debug_mode_i) ||
    w_fp_ill;

  assign w_ecall = data_i == W_ECALL;
  assign w_ebrk = data_i == W_EBRK;
  assign w_op = (w_fu <= FU_CSR) ? {data_i[30], w_f3} : 4'd0;

  logic [ID_W-1:0] r_id;

  // register one decoded beat per accepted word and advance the ID
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_id <= '0;
      valid_o <= 1'b0;
      id_o <= '0;
      pc_o <= '0;
      tinst_o <= '0;
      si_valid_o <= 1'b0;
      fu_o <= '0;
      op_o <= '0;
      rd_o <= '0;
      rs1_o <= '0;
      rs2_o <= '0;
      imm_o <= '0;
      exc_valid_o <= 1'b0;
      exc_cause_o <= '0;
      exc_tval_o <= '0;
    end else if (input_ready_i) begin
      r_id <= r_id + 1'b1;
      valid_o <= 1'b1;
      id_o <= r_id;
      pc_o <= pc_i;
      tinst_o <= data_i;
      si_valid_o <= w_sv;
      op_o <= w_op;
      rd_o <= data_i[11:7];
      rs1_o <= data_i[19:15];
      rs2_o <= data_i[24:20];
      imm_o <= w_imm;
      if (w_ill) begin
        fu_o <= FU_NONE;
        exc_valid_o <= 1'b1;
        exc_cause_o <= 4'd2;
        exc_tval_o <= {{(XLEN-32){1'b0}}, data_i};
      end else if (w_ecall) begin
        fu_o <= FU_NONE;
        exc_valid_o <= 1'b1;
        exc_cause_o <= {2'b10, priv_lvl_i};
        exc_tval_o <= '0;
      end else if (w_ebrk) begin
        fu_o <= FU_NONE;
        exc_valid_o <= 1'b1;
        exc_cause_o <= 4'd3;
        exc_tval_o <= pc_i;
      end else begin
        fu_o <= w_fu;
        exc_valid_o <= 1'b0;
        exc_cause_o <= '0;
        exc_tval_o <= '0;
      end
    end else begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage with hand-computed expectations.
// FP cases are exercised when DECODER_FP_EN is defined.
module tb_rv_decode_stage;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] pc_i = '0;
  logic [31:0] data_i = '0;
  logic        input_ready_i = 1'b0;
  logic [1:0]  fs_i = 2'd0;
  logic [1:0]  priv_lvl_i = 2'd3;
  logic [2:0]  frm_i = 3'd0;
  logic        tvm_i = 1'b0;
  logic        tw_i = 1'b0;
  logic        tsr_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic        valid_o;
  logic [19:0] id_o;
  logic [63:0] pc_o;
  logic [31:0] tinst_o;
  logic        si_valid_o;
  logic [2:0]  fu_o;
  logic [3:0]  op_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [63:0] imm_o;
  logic        exc_valid_o;
  logic [3:0]  exc_cause_o;
  logic [63:0] exc_tval_o;

  int n_cmp = 0;
  int n_bad = 0;

  rv_decode_stage dut (
    .clk(clk), .rstn(rstn), .pc_i(pc_i), .data_i(data_i),
    .input_ready_i(input_ready_i), .fs_i(fs_i),
    .priv_lvl_i(priv_lvl_i), .frm_i(frm_i), .tvm_i(tvm_i),
    .tw_i(tw_i), .tsr_i(tsr_i), .debug_mode_i(debug_mode_i),
    .valid_o(valid_o), .id_o(id_o), .pc_o(pc_o),
    .tinst_o(tinst_o), .si_valid_o(si_valid_o), .fu_o(fu_o),
    .op_o(op_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .imm_o(imm_o), .exc_valid_o(exc_valid_o),
    .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [63:0] pc);
    data_i = d;
    pc_i = pc;
    input_ready_i = 1'b1;
    @(posedge clk);
    #1;
    input_ready_i = 1'b0;
  endtask

  task automatic idle();
    input_ready_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic chk_exc(input string tag, input logic ev,
                         input logic [3:0] c, input logic [63:0] tv);
    chk({tag, "_ev"}, 64'(exc_valid_o), 64'(ev));
    chk({tag, "_cause"}, 64'(exc_cause_o), 64'(c));
    chk({tag, "_tval"}, exc_tval_o, tv);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_id", 64'(id_o), 64'd0);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_exc", 64'(exc_valid_o), 64'd0);
    chk("rst_fu", 64'(fu_o), 64'd0);

    beat(32'h0050_0093, 64'h100);
    chk("addi_valid", 64'(valid_o), 64'd1);
    chk("addi_id", 64'(id_o), 64'd0);
    chk("addi_pc", pc_o, 64'h100);
    chk("addi_sv", 64'(si_valid_o), 64'd1);
    chk("addi_fu", 64'(fu_o), 64'd0);
    chk("addi_rd", 64'(rd_o), 64'd1);
    chk("addi_rs1", 64'(rs1_o), 64'd0);
    chk("addi_imm", imm_o, 64'd5);
    chk("addi_tinst", 64'(tinst_o), 64'h0050_0093);
    chk_exc("addi", 1'b0, 4'd0, 64'd0);

    do_reset();
    beat(32'h0050_0093, 64'h200);
    chk("seq_id0", 64'(id_o), 64'd0);
    beat(32'h0050_0093, 64'h204);
    chk("seq_id1", 64'(id_o), 64'd1);
    beat(32'h0050_0093, 64'h208);
    chk("seq_id2", 64'(id_o), 64'd2);
    idle();
    chk("seq_idle_valid", 64'(valid_o), 64'd0);
    beat(32'h0050_0093, 64'h20c);
    chk("seq_id3", 64'(id_o), 64'd3);
    chk("seq_valid3", 64'(valid_o), 64'd1);

    rstn = 1'b0;
    data_i = 32'h0050_0093;
    input_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    input_ready_i = 1'b0;
    chk("rstpri_valid", 64'(valid_o), 64'd0);
    chk("rstpri_id", 64'(id_o), 64'd0);
    beat(32'h0050_0093, 64'h300);
    chk("postrst_id", 64'(id_o), 64'd0);

    beat(32'h1234_50b7, 64'h0);
    chk("lui_fu", 64'(fu_o), 64'd0);
    chk("lui_imm", imm_o, 64'h1234_5000);
    chk("lui_rd", 64'(rd_o), 64'd1);

    beat(32'hffdf_f0ef, 64'h0);
    chk("jal_fu", 64'(fu_o), 64'd1);
    chk("jal_imm", imm_o, 64'hffff_ffff_ffff_fffc);

    beat(32'h0020_b423, 64'h0);
    chk("sd_fu", 64'(fu_o), 64'd2);
    chk("sd_imm", imm_o, 64'd8);
    chk("sd_op", 64'(op_o), 64'd3);
    chk("sd_rs2", 64'(rs2_o), 64'd2);

    priv_lvl_i = 2'd0;
    beat(32'h3000_1073, 64'h0);
    chk_exc("csr_u", 1'b1, 4'd2, 64'h3000_1073);
    chk("csr_u_fu", 64'(fu_o), 64'd7);
    priv_lvl_i = 2'd3;
    beat(32'h3000_1073, 64'h0);
    chk_exc("csr_m", 1'b0, 4'd0, 64'd0);
    chk("csr_m_fu", 64'(fu_o), 64'd3);
    chk("csr_m_op", 64'(op_o), 64'd1);

    beat(32'hc000_2073, 64'h0);
    chk_exc("ro_rd", 1'b0, 4'd0, 64'd0);
    beat(32'hc000_9073, 64'h0);
    chk_exc("ro_wr", 1'b1, 4'd2, 64'hc000_9073);

    priv_lvl_i = 2'd1;
    beat(32'h3020_0073, 64'h0);
    chk_exc("mret_s", 1'b1, 4'd2, 64'h3020_0073);
    tw_i = 1'b1;
    beat(32'h1050_0073, 64'h0);
    chk_exc("wfi_tw1", 1'b1, 4'd2, 64'h1050_0073);
    tw_i = 1'b0;
    beat(32'h1050_0073, 64'h0);
    chk_exc("wfi_tw0", 1'b0, 4'd0, 64'd0);
    chk("wfi_fu", 64'(fu_o), 64'd3);
    tsr_i = 1'b1;
    beat(32'h1020_0073, 64'h0);
    chk_exc("sret_tsr", 1'b1, 4'd2, 64'h1020_0073);
    tsr_i = 1'b0;
    beat(32'h1020_0073, 64'h0);
    chk_exc("sret_ok", 1'b0, 4'd0, 64'd0);
    beat(32'h0000_0073, 64'h0);
    chk_exc("ecall_s", 1'b1, 4'd9, 64'd0);

    priv_lvl_i = 2'd3;
    beat(32'h0000_0073, 64'h0);
    chk_exc("ecall_m", 1'b1, 4'd11, 64'd0);
    chk("ecall_fu", 64'(fu_o), 64'd7);
    beat(32'h0010_0073, 64'h40);
    chk_exc("ebreak", 1'b1, 4'd3, 64'h40);
    beat(32'h7b20_0073, 64'h0);
    chk_exc("dret", 1'b1, 4'd2, 64'h7b20_0073);
    beat(32'h0000_0000, 64'h0);
    chk("zero_sv", 64'(si_valid_o), 64'd0);
    chk_exc("zero", 1'b1, 4'd2, 64'd0);
    chk("zero_valid", 64'(valid_o), 64'd1);

`ifdef DECODER_FP_EN
    fs_i = 2'd0;
    beat(32'h0010_7053, 64'h0);
    chk_exc("fp_off", 1'b1, 4'd2, 64'h0010_7053);
    fs_i = 2'd1;
    frm_i = 3'd5;
    beat(32'h0010_7053, 64'h0);
    chk_exc("fp_frm5", 1'b1, 4'd2, 64'h0010_7053);
    frm_i = 3'd0;
    beat(32'h0010_7053, 64'h0);
    chk_exc("fp_ok", 1'b0, 4'd0, 64'd0);
    chk("fp_fu", 64'(fu_o), 64'd4);
`else
    fs_i = 2'd1;
    beat(32'h0010_7053, 64'h0);
    chk("fp_dis_sv", 64'(si_valid_o), 64'd0);
    chk_exc("fp_dis", 1'b1, 4'd2, 64'h0010_7053);
`endif

    idle();
    chk("end_idle_valid", 64'(valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Two-part RISC-V instruction decoder: a combinational static stage decodes a 32-bit word, and a registered dynamic stage applies privilege, CSR and FP-state legality checks. It sits between instruction fetch and issue. It emits one decoded, ID-tagged instruction per accepted fetch word, with any synchronous exception attached.

## Interface
- XLEN, 64, datapath and PC width
- ID_W, 20, instruction ID counter width

- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- pc_i  in  XLEN  PC of data_i
- data_i  in  32  raw instruction word
- input_ready_i  in  1  data_i/pc_i valid this cycle (accepted unconditionally)
- fs_i  in  2  FP state: 0 Off, 1 Initial, 2 Clean, 3 Dirty
- priv_lvl_i  in  2  0 U, 1 S, 3 M
- frm_i  in  3  dynamic rounding mode (fcsr.frm)
- tvm_i, tw_i, tsr_i  in  1 each  mstatus trap bits
- debug_mode_i  in  1  hart in debug mode
- valid_o  out  1  decoded instruction present
- id_o  out  ID_W  sequence ID
- pc_o  out  XLEN  registered pc_i
- tinst_o  out  32  registered data_i
- si_valid_o  out  1  statically well-formed instruction
- fu_o  out  3  0 ALU, 1 BRU, 2 LSU, 3 CSR, 4 FPU, 7 NONE
- op_o  out  4  {funct7[5], funct3} for ALU/BRU/LSU/CSR; 0 otherwise
- rd_o, rs1_o, rs2_o  out  5 each  register fields
- imm_o  out  XLEN  sign-extended immediate
- exc_valid_o  out  1  synchronous exception
- exc_cause_o  out  4  mcause code
- exc_tval_o  out  XLEN  trap value

## Operation
- Static stage, combinational, RV64I + Zicsr + SYSTEM:
  - si_valid is 0 when data_i[1:0]≠2'b11, when data_i==0, or for an unknown opcode/funct3/funct7.
  - Immediates: I/S/B/U/J types, sign-extended to XLEN.
  - CSR immediate forms zero-extend rs1 into imm.
- FU mapping:
  - LUI, AUIPC, OP, OP-IMM, OP-32, OP-IMM-32 → ALU
  - JAL, JALR, BRANCH → BRU
  - LOAD, STORE, MISC-MEM → LSU
  - SYSTEM → CSR
  - FP opcodes → FPU (see Configuration)
- Dynamic checks raise illegal instruction (cause 2, tval = instruction word). The first matching rule wins:
  - si_valid=0.
  - CSR address bits [9:8] > priv_lvl_i.
  - Write to a read-only CSR (addr[11:10]==3). CSRRW/CSRRWI always write. CSRRS/CSRRC/CSRRSI/CSRRCI write only when rs1/uimm≠0.
  - satp (0x180) access in S with tvm_i=1.
  - MRET when priv≠M.
  - SRET when priv=U, or when priv=S with tsr_i=1.
  - WFI when tw_i=1 and priv≠M.
  - SFENCE.VMA when priv=U, or when priv=S with tvm_i=1.
  - DRET when debug_mode_i=0.
- Other exceptions, applied only when no illegal rule matched:
  - ECALL: cause 8 (U), 9 (S) or 11 (M), tval 0.
  - EBREAK: cause 3, tval=pc_i.
- With an exception, valid_o still asserts and fu_o=NONE.
- Each accepted instruction receives the current ID, then the counter increments and wraps at 2^ID_W.

## Timing
- One-cycle latency: input_ready_i=1 at edge N gives valid_o=1 with all fields from that beat after edge N.
- input_ready_i=0 at an edge gives valid_o=0 next cycle. The other outputs are don't-care but hold their values.
- No backpressure: every beat is accepted.
- Reset (rstn=0 at an edge) has priority over input_ready_i:
  - Clears valid_o, the ID counter and all registered outputs to 0.
  - The first post-reset instruction gets id 0.
- Dynamic inputs (priv_lvl_i, fs_i, etc.) are sampled in the same cycle as data_i.

## Configuration
- DECODER_FP_EN defined: decode LOAD-FP, STORE-FP, OP-FP and FMADD-family opcodes (F/D) as FPU.
  - fs_i=Off → illegal.
  - rm ∈ {5,6} → illegal.
  - rm=7 with frm_i ∈ {5,6,7} → illegal.
- DECODER_FP_EN undefined: those opcodes have si_valid=0 (illegal); fs_i and frm_i are ignored.

## Test plan
- Reset, then 0x00500093 (addi x1,x0,5) at pc 0x100 → next cycle: valid_o=1, id 0, fu ALU, rd 1, rs1 0, imm 5, no exception.
- Three back-to-back beats, one idle cycle, then a fourth beat → ids 0,1,2, then valid_o=0, then id 3. Reset mid-stream → next id 0.
- 0x30001073 (csrrw mstatus) at priv U → cause 2, tval 0x30001073. The same word at priv M → legal, fu CSR.
- 0x30200073 (mret) at priv S → illegal. 0x10500073 (wfi) at priv S with tw_i=1 → illegal; with tw_i=0 → legal.
- 0x00000073 at priv M → cause 11. 0x00100073 at pc 0x40 → cause 3, tval 0x40. 0x00000000 → si_valid=0, cause 2.
- DECODER_FP_EN, 0x00107053 (fadd.s rm=dyn):
  - fs_i=0 → illegal.
  - fs_i=1, frm_i=5 → illegal.
  - fs_i=1, frm_i=0 → legal, fu FPU.
